// File: rtl/sys1_input_pkg.sv
// Shared constants and types for the system-1 input controller: PS/2 scan codes,
// coin shaper states, button register layout and game input byte bit positions.
package sys1_input_pkg;

    // Arrow keys match on the low byte only so both plain and extended codes work
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    localparam logic [8:0] KEY_TRIG1     = 9'h029;
    localparam logic [8:0] KEY_TRIG2     = 9'h014;
    localparam logic [8:0] KEY_F1        = 9'h005;
    localparam logic [8:0] KEY_F2        = 9'h006;
    localparam logic [8:0] KEY_START1    = 9'h016;
    localparam logic [8:0] KEY_START2    = 9'h01E;
    localparam logic [8:0] KEY_COIN1     = 9'h02E;
    localparam logic [8:0] KEY_COIN2     = 9'h036;
    localparam logic [8:0] KEY_P2_UP     = 9'h02D;
    localparam logic [8:0] KEY_P2_DOWN   = 9'h02B;
    localparam logic [8:0] KEY_P2_LEFT   = 9'h023;
    localparam logic [8:0] KEY_P2_RIGHT  = 9'h034;
    localparam logic [8:0] KEY_P2_TRIG1  = 9'h01C;
    localparam logic [8:0] KEY_P2_TRIG2  = 9'h01B;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP,
        WAIT_REL
    } coin_state_e;

    localparam int INP_LEFT_BIT   = 7;
    localparam int INP_RIGHT_BIT  = 6;
    localparam int INP_TRIG_BIT   = 2;
    localparam int INP_START2_BIT = 5;
    localparam int INP_START1_BIT = 4;
    localparam int INP_COIN_BIT   = 0;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic trig1;
        logic trig2;
        logic f1;
        logic f2;
        logic start1;
        logic start2;
        logic coin1;
        logic coin2;
        logic p2_up;
        logic p2_down;
        logic p2_left;
        logic p2_right;
        logic p2_trig1;
        logic p2_trig2;
    } buttons_t;

endpackage

// File: rtl/sys1_coin_shaper.sv
// Turns a coin request level into one frame-timed coin pulse followed by a lockout,
// and refuses to fire again until the request has been released.
module sys1_coin_shaper
    import sys1_input_pkg::*;
#(
    parameter int unsigned COIN_FRAMES = 4,
    parameter int unsigned COIN_GAP    = 2
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic coin_req,
    input  logic tick,
    output logic coin_out,
    output logic busy
);

    localparam logic [3:0] FRAMES_L = 4'(COIN_FRAMES);
    localparam logic [3:0] GAP_L    = 4'(COIN_GAP);

    coin_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        req_rise;

    // The request history resets high so a coin already held through reset is not an edge
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = coin_req;
        req_rise = coin_req & ~req_q;

        unique case (state_q)
            IDLE: begin
                if (req_rise) begin
                    state_d = PULSE;
                    cnt_d   = FRAMES_L;
                end
            end
            PULSE: begin
                if (cnt_q == 4'd0) begin
                    if (GAP_L == 4'd0) begin
                        state_d = WAIT_REL;
                    end else begin
                        state_d = GAP;
                        cnt_d   = GAP_L;
                    end
                end else if (tick) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            GAP: begin
                if (cnt_q == 4'd0) begin
                    state_d = WAIT_REL;
                end else if (tick) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WAIT_REL: begin
                if (!coin_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign coin_out = (state_q == PULSE);
    assign busy     = (state_q != IDLE);

endmodule

// File: rtl/sys1_input_ctrl.sv
// Merges PS/2 keyboard events and two joysticks into the three active-low game
// input bytes, with a frame-timed coin pulse on INP2[0].
module sys1_input_ctrl
    import sys1_input_pkg::*;
#(
    parameter int unsigned COIN_FRAMES = 4,
    parameter int unsigned COIN_GAP    = 2,
    parameter int unsigned COCKTAIL    = 0
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystk1,
    input  logic [15:0] joystk2,
    input  logic        vblank,
    output logic [7:0]  INP0,
    output logic [7:0]  INP1,
    output logic [7:0]  INP2,
    output logic        coin_busy
);

    localparam logic MIX_P2 = (COCKTAIL == 0);

    logic       toggle_q, vblank_q, started_q;
    buttons_t   btn_q, btn_d;
    logic [7:0] inp0_q, inp0_d, inp1_q, inp1_d, inp2_q, inp2_d;

    logic       key_event, frame_tick, pressed;
    logic [8:0] scan_code;
    logic       left1, right1, trig1, left2, right2, trig2_1;
    logic       start1, start2, coin_req, coin_out;

    assign scan_code = ps2_key[8:0];
    assign pressed   = ps2_key[9];

    // started_q masks the first cycle after reset so a stale toggle/vblank level is not an edge
    assign key_event  = started_q & (ps2_key[10] ^ toggle_q);
    assign frame_tick = started_q & vblank & ~vblank_q;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            toggle_q  <= 1'b0;
            vblank_q  <= 1'b0;
            started_q <= 1'b0;
            btn_q     <= '0;
            inp0_q    <= 8'hFF;
            inp1_q    <= 8'hFF;
            inp2_q    <= 8'hFF;
        end else begin
            toggle_q  <= ps2_key[10];
            vblank_q  <= vblank;
            started_q <= 1'b1;
            btn_q     <= btn_d;
            inp0_q    <= inp0_d;
            inp1_q    <= inp1_d;
            inp2_q    <= inp2_d;
        end
    end

    always_comb begin
        btn_d = btn_q;
        if (key_event) begin
            if (scan_code[7:0] == KEY_UP) begin
                btn_d.up = pressed;
            end else if (scan_code[7:0] == KEY_DOWN) begin
                btn_d.down = pressed;
            end else if (scan_code[7:0] == KEY_LEFT) begin
                btn_d.left = pressed;
            end else if (scan_code[7:0] == KEY_RIGHT) begin
                btn_d.right = pressed;
            end else begin
                case (scan_code)
                    KEY_TRIG1:    btn_d.trig1    = pressed;
                    KEY_TRIG2:    btn_d.trig2    = pressed;
                    KEY_F1:       btn_d.f1       = pressed;
                    KEY_F2:       btn_d.f2       = pressed;
                    KEY_START1:   btn_d.start1   = pressed;
                    KEY_START2:   btn_d.start2   = pressed;
                    KEY_COIN1:    btn_d.coin1    = pressed;
                    KEY_COIN2:    btn_d.coin2    = pressed;
                    KEY_P2_UP:    btn_d.p2_up    = pressed;
                    KEY_P2_DOWN:  btn_d.p2_down  = pressed;
                    KEY_P2_LEFT:  btn_d.p2_left  = pressed;
                    KEY_P2_RIGHT: btn_d.p2_right = pressed;
                    KEY_P2_TRIG1: btn_d.p2_trig1 = pressed;
                    KEY_P2_TRIG2: btn_d.p2_trig2 = pressed;
                    default: ;
                endcase
            end
        end
    end

    assign left2   = btn_q.p2_left  | joystk2[1];
    assign right2  = btn_q.p2_right | joystk2[0];
    assign trig2_1 = btn_q.p2_trig1 | joystk2[4];

    // In upright cabinets player 2 controls also drive player 1
    assign left1  = btn_q.left  | joystk1[1] | (MIX_P2 & left2);
    assign right1 = btn_q.right | joystk1[0] | (MIX_P2 & right2);
    assign trig1  = btn_q.trig1 | joystk1[4] | (MIX_P2 & trig2_1);

    assign start1   = btn_q.f1 | btn_q.start1 | joystk1[5] | joystk2[5];
    assign start2   = btn_q.f2 | btn_q.start2 | joystk1[6] | joystk2[6];
    assign coin_req = btn_q.f1 | btn_q.f2 | btn_q.coin1 | btn_q.coin2 | joystk1[7] | joystk2[7];

    always_comb begin
        inp0_d = 8'hFF;
        inp1_d = 8'hFF;
        inp2_d = 8'hFF;
        inp0_d[INP_LEFT_BIT]   = ~left1;
        inp0_d[INP_RIGHT_BIT]  = ~right1;
        inp0_d[INP_TRIG_BIT]   = ~trig1;
        inp1_d[INP_LEFT_BIT]   = ~left2;
        inp1_d[INP_RIGHT_BIT]  = ~right2;
        inp1_d[INP_TRIG_BIT]   = ~trig2_1;
        inp2_d[INP_START2_BIT] = ~start2;
        inp2_d[INP_START1_BIT] = ~start1;
        inp2_d[INP_COIN_BIT]   = ~coin_out;
    end

    sys1_coin_shaper #(
        .COIN_FRAMES(COIN_FRAMES),
        .COIN_GAP   (COIN_GAP)
    ) u_coin_shaper (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .coin_req(coin_req),
        .tick    (frame_tick),
        .coin_out(coin_out),
        .busy    (coin_busy)
    );

    assign INP0 = inp0_q;
    assign INP1 = inp1_q;
    assign INP2 = inp2_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, joystk1[15:8], joystk1[3:2], joystk2[15:8], joystk2[3:2],
                         btn_q.up, btn_q.down, btn_q.trig2,
                         btn_q.p2_up, btn_q.p2_down, btn_q.p2_trig2};

endmodule

// File: tb/tb_sys1_input_ctrl.sv
// Scoreboard bench for sys1_input_ctrl: upright and cocktail instances share stimulus,
// key/joystick mapping is checked through a queue, coin timing through a frame monitor.
module tb_sys1_input_ctrl;

    logic        clk;
    logic        rst_n;
    logic [10:0] ps2_key;
    logic [15:0] joystk1, joystk2;
    logic        vblank;
    logic [7:0]  inp0_a, inp1_a, inp2_a, inp0_b, inp1_b, inp2_b;
    logic        busy_a, busy_b;

    int check_count = 0;
    int error_count = 0;

    logic key_toggle = 1'b0;
    logic frame_en   = 1'b0;
    int   pulse_ticks  = 0;
    int   pulse_starts = 0;
    int   busy_drops   = 0;
    logic watch_busy   = 1'b0;

    typedef struct {
        string      tag;
        logic [7:0] e0, e1, e2, c0, c1;
    } exp_t;

    exp_t exp_q[$];

    sys1_input_ctrl #(.COIN_FRAMES(4), .COIN_GAP(2), .COCKTAIL(0)) dut_a (
        .clk_sys(clk), .rst_n(rst_n), .ps2_key(ps2_key), .joystk1(joystk1), .joystk2(joystk2),
        .vblank(vblank), .INP0(inp0_a), .INP1(inp1_a), .INP2(inp2_a), .coin_busy(busy_a)
    );

    sys1_input_ctrl #(.COIN_FRAMES(4), .COIN_GAP(2), .COCKTAIL(1)) dut_b (
        .clk_sys(clk), .rst_n(rst_n), .ps2_key(ps2_key), .joystk1(joystk1), .joystk2(joystk2),
        .vblank(vblank), .INP0(inp0_b), .INP1(inp1_b), .INP2(inp2_b), .coin_busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Frames are 8 cycles with vblank high for the last 2; a tick issued here is
    // credited to the pulse if INP2[0] is low at the following negedge.
    initial begin
        int   frame_cnt;
        logic last_tick, prev_coin, new_v;
        frame_cnt = 0;
        last_tick = 1'b0;
        prev_coin = 1'b1;
        vblank    = 1'b0;
        forever begin
            @(negedge clk);
            if (last_tick && inp2_a[0] == 1'b0) pulse_ticks++;
            if (prev_coin && inp2_a[0] == 1'b0) pulse_starts++;
            if (watch_busy && !busy_a) busy_drops++;
            prev_coin = inp2_a[0];
            last_tick = 1'b0;
            if (frame_en) begin
                frame_cnt = (frame_cnt == 7) ? 0 : frame_cnt + 1;
                new_v     = (frame_cnt >= 6);
                last_tick = new_v && !vblank;
                vblank    = new_v;
            end else begin
                vblank = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic sendKey(input logic pressed, input logic [8:0] code);
        key_toggle = ~key_toggle;
        ps2_key    = {key_toggle, pressed, code};
    endtask

    task automatic drainScoreboard();
        exp_t item;
        while (exp_q.size() > 0) begin
            item = exp_q.pop_front();
            checkOutput({item.tag, "_a0"}, {8'h00, inp0_a}, {8'h00, item.e0});
            checkOutput({item.tag, "_a1"}, {8'h00, inp1_a}, {8'h00, item.e1});
            checkOutput({item.tag, "_a2"}, {8'h00, inp2_a}, {8'h00, item.e2});
            checkOutput({item.tag, "_b0"}, {8'h00, inp0_b}, {8'h00, item.c0});
            checkOutput({item.tag, "_b1"}, {8'h00, inp1_b}, {8'h00, item.c1});
        end
    endtask

    task automatic applyStimulus(input string tag, input logic do_key, input logic pressed,
                                 input logic [8:0] code, input logic [15:0] j1, input logic [15:0] j2,
                                 input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                                 input logic [7:0] c0, input logic [7:0] c1);
        exp_t item;
        @(negedge clk);
        if (do_key) sendKey(pressed, code);
        joystk1 = j1;
        joystk2 = j2;
        item.tag = tag;
        item.e0 = e0; item.e1 = e1; item.e2 = e2; item.c0 = c0; item.c1 = c1;
        exp_q.push_back(item);
        repeat (2) @(negedge clk);
        drainScoreboard();
    endtask

    task automatic zeroCounters();
        pulse_ticks  = 0;
        pulse_starts = 0;
        busy_drops   = 0;
    endtask

    initial begin
        rst_n   = 1'b0;
        ps2_key = '0;
        joystk1 = '0;
        joystk2 = '0;

        repeat (3) @(negedge clk);
        checkOutput("rst_inp0", {8'h00, inp0_a}, 16'h00FF);
        checkOutput("rst_inp1", {8'h00, inp1_a}, 16'h00FF);
        checkOutput("rst_inp2", {8'h00, inp2_a}, 16'h00FF);
        checkOutput("rst_busy", {15'd0, busy_a}, 16'd0);

        // Toggle already flipped while in reset must not be taken as an event
        key_toggle = 1'b1;
        ps2_key    = {1'b1, 1'b1, 9'h06B};
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("no_spurious", {8'h00, inp0_a}, 16'h00FF);

        //             tag          key  prs  code    j1       j2       e0     e1     e2     c0     c1
        applyStimulus("left_p",    1, 1, 9'h06B, 16'h0, 16'h0, 8'h7F, 8'hFF, 8'hFF, 8'h7F, 8'hFF);
        applyStimulus("left_r",    1, 0, 9'h06B, 16'h0, 16'h0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        applyStimulus("rightx_p",  1, 1, 9'h174, 16'h0, 16'h0, 8'hBF, 8'hFF, 8'hFF, 8'hBF, 8'hFF);
        applyStimulus("rightx_r",  1, 0, 9'h174, 16'h0, 16'h0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        applyStimulus("j2trig",    0, 0, 9'h000, 16'h0, 16'h0010, 8'hFB, 8'hFB, 8'hFF, 8'hFF, 8'hFB);
        applyStimulus("p2left_p",  1, 1, 9'h023, 16'h0, 16'h0, 8'h7F, 8'h7F, 8'hFF, 8'hFF, 8'h7F);
        applyStimulus("p2left_r",  1, 0, 9'h023, 16'h0, 16'h0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        applyStimulus("unmapped",  1, 1, 9'h0AA, 16'h0, 16'h0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        applyStimulus("trigx",     1, 1, 9'h129, 16'h0, 16'h0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        applyStimulus("trig_p",    1, 1, 9'h029, 16'h0, 16'h0, 8'hFB, 8'hFF, 8'hFF, 8'hFB, 8'hFF);
        applyStimulus("trig_r",    1, 0, 9'h029, 16'h0, 16'h0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        applyStimulus("j1lr",      0, 0, 9'h000, 16'h0003, 16'h0, 8'h3F, 8'hFF, 8'hFF, 8'h3F, 8'hFF);
        applyStimulus("start2k_p", 1, 1, 9'h01E, 16'h0, 16'h0, 8'hFF, 8'hFF, 8'hDF, 8'hFF, 8'hFF);
        applyStimulus("start2k_r", 1, 0, 9'h01E, 16'h0, 16'h0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        applyStimulus("j2start2",  0, 0, 9'h000, 16'h0, 16'h0040, 8'hFF, 8'hFF, 8'hDF, 8'hFF, 8'hFF);
        applyStimulus("j1start1",  0, 0, 9'h000, 16'h0020, 16'h0, 8'hFF, 8'hFF, 8'hEF, 8'hFF, 8'hFF);
        applyStimulus("p2right_p", 1, 1, 9'h034, 16'h0, 16'h0, 8'hBF, 8'hBF, 8'hFF, 8'hFF, 8'hBF);
        applyStimulus("p2right_r", 1, 0, 9'h034, 16'h0, 16'h0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        applyStimulus("leftx_p",   1, 1, 9'h16B, 16'h0, 16'h0, 8'h7F, 8'hFF, 8'hFF, 8'h7F, 8'hFF);
        applyStimulus("leftx_r",   1, 0, 9'h16B, 16'h0, 16'h0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

        // Key latency: not yet visible after one edge, visible after the second
        @(negedge clk);
        sendKey(1'b1, 9'h074);
        @(negedge clk);
        checkOutput("key_lat1", {8'h00, inp0_a}, 16'h00FF);
        @(negedge clk);
        checkOutput("key_lat2", {8'h00, inp0_a}, 16'h00BF);
        sendKey(1'b0, 9'h074);
        repeat (2) @(negedge clk);
        joystk1 = 16'h0002;
        @(negedge clk);
        checkOutput("joy_lat1", {8'h00, inp0_a}, 16'h007F);
        joystk1 = 16'h0;
        repeat (2) @(negedge clk);

        // Coin held for 20 frames gives one 4-tick pulse and stays busy
        frame_en = 1'b1;
        repeat (16) @(negedge clk);
        zeroCounters();
        joystk1 = 16'h0080;
        repeat (4) @(negedge clk);
        watch_busy = 1'b1;
        repeat (156) @(negedge clk);
        checkOutput("hold_starts", 16'(pulse_starts), 16'd1);
        checkOutput("hold_ticks", 16'(pulse_ticks), 16'd4);
        checkOutput("hold_busy_drops", 16'(busy_drops), 16'd0);
        checkOutput("hold_busy", {15'd0, busy_a}, 16'd1);
        watch_busy = 1'b0;
        joystk1 = 16'h0;
        repeat (3) @(negedge clk);
        checkOutput("hold_rel_busy", {15'd0, busy_a}, 16'd0);

        // A re-press during the pulse is ignored and not queued
        zeroCounters();
        joystk1 = 16'h0080;
        repeat (8) @(negedge clk);
        joystk1 = 16'h0;
        repeat (16) @(negedge clk);
        joystk1 = 16'h0080;
        repeat (2) @(negedge clk);
        checkOutput("repress_in_pulse", {15'd0, inp2_a[0]}, 16'd0);
        checkOutput("repress_starts", 16'(pulse_starts), 16'd1);
        joystk1 = 16'h0;
        repeat (64) @(negedge clk);
        checkOutput("repress_idle", {15'd0, busy_a}, 16'd0);
        checkOutput("repress_one_pulse", 16'(pulse_ticks), 16'd4);
        joystk1 = 16'h0080;
        repeat (4) @(negedge clk);
        checkOutput("third_starts", 16'(pulse_starts), 16'd2);
        repeat (60) @(negedge clk);
        joystk1 = 16'h0;
        repeat (4) @(negedge clk);
        checkOutput("third_ticks", 16'(pulse_ticks), 16'd8);

        // F1 gives start1 plus a coin; the coin ends while start1 holds
        zeroCounters();
        sendKey(1'b1, 9'h005);
        repeat (3) @(negedge clk);
        checkOutput("f1_inp2", {8'h00, inp2_a}, 16'h00EE);
        repeat (56) @(negedge clk);
        checkOutput("f1_after", {8'h00, inp2_a}, 16'h00EF);
        checkOutput("f1_ticks", 16'(pulse_ticks), 16'd4);
        sendKey(1'b0, 9'h005);
        repeat (4) @(negedge clk);
        checkOutput("f1_rel", {8'h00, inp2_a}, 16'h00FF);
        checkOutput("f1_rel_busy", {15'd0, busy_a}, 16'd0);

        // Reset mid-pulse clears INP2 at once; coin held through reset does not fire
        joystk1 = 16'h0080;
        repeat (20) @(negedge clk);
        checkOutput("pre_rst_pulse", {15'd0, inp2_a[0]}, 16'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_inp2", {8'h00, inp2_a}, 16'h00FF);
        checkOutput("async_rst_busy", {15'd0, busy_a}, 16'd0);
        repeat (2) @(negedge clk);
        zeroCounters();
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("held_no_start", 16'(pulse_starts), 16'd0);
        checkOutput("held_no_busy", {15'd0, busy_a}, 16'd0);
        joystk1 = 16'h0;
        repeat (3) @(negedge clk);
        joystk1 = 16'h0080;
        repeat (4) @(negedge clk);
        checkOutput("after_rst_pulse", {15'd0, inp2_a[0]}, 16'd0);
        joystk1 = 16'h0;
        repeat (70) @(negedge clk);
        checkOutput("final_idle", {15'd0, busy_a}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
